// File: rtl/seq_mult8x8_if.sv
// seq_mult8x8_if: start/operand/result handshake bundle for the sequential multiplier.
interface seq_mult8x8_if;
  logic start;
  logic [7:0] a;
  logic [7:0] b;
  logic [15:0] p;
  logic busy;
  logic done;
  modport master (output start, a, b, input p, busy, done);
  modport slave (input start, a, b, output p, busy, done);
endinterface

// File: rtl/seq_mult8x8.sv
// seq_mult8x8: unsigned 8x8 shift-and-add multiplier, one iteration per cycle, 16-bit registered product.
module mux21x8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       s,
  output logic [7:0] y
);
  assign y = s ? b : a;
endmodule

module seq_mult8x8 (
  input logic       clk,
  input logic       reset_b,
  seq_mult8x8_if.slave m
);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  logic [1:0] state;
  logic [7:0] mcand, acc, q, addend;
  logic [2:0] cnt;
  logic [8:0] sum;
  logic [15:0] p;
  mux21x8 u_mux (.a(8'h00), .b(mcand), .s(q[0]), .y(addend));
  // carry kept in sum[8] so it shifts into acc[7]
  assign sum = {1'b0, acc} + {1'b0, addend};
  assign m.p = p;
  assign m.busy = state != IDLE;
  assign m.done = state == DONE;
  always_ff @(posedge clk or negedge reset_b)
    if (!reset_b) begin
      state <= IDLE;
      mcand <= '0;
      acc <= '0;
      q <= '0;
      cnt <= '0;
      p <= '0;
    end else
      case (state)
        IDLE: if (m.start) begin
          mcand <= m.a;
          q <= m.b;
          acc <= '0;
          cnt <= '0;
          state <= RUN;
        end
        RUN: begin
          {acc, q} <= {sum, q[7:1]};
          cnt <= cnt + 3'd1;
          if (cnt == 3'd7) begin
            p <= {sum, q[7:1]};
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
endmodule
